// File: rtl/fll_cfg_bridge.sv
// APB slave bridging 32-bit register accesses onto the FLL four-phase req/ack
// configuration port, with lock synchroniser, sticky timeout status and abort.
module fll_cfg_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc_s;
  logic        req_q, req_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        wrn_q, wrn_d;
  logic [1:0]  add_q, add_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sticky_q, sticky_d;
  logic        sticky_set_s, sticky_clr_s;
  logic        lock_meta_q, lock_sync_q;
  logic        access_s;
  logic        unused_addr_s;

  assign access_s      = psel_i & penable_i;
  assign cnt_inc_s     = cnt_q + 16'd1;
  assign unused_addr_s = &{1'b0, paddr_i[11:5], paddr_i[1:0]};

  // Next-state, output and status computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = 1'b0;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = 32'h0000_0000;
    wrn_d        = wrn_q;
    add_d        = add_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    sticky_set_s = 1'b0;
    sticky_clr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          if (paddr_i[4] == 1'b0) begin
            // A still-high ack belongs to an aborted transaction; wait it out
            if (fll_ack_i == 1'b0) begin
              state_d = REQ;
              cnt_d   = 16'd0;
              req_d   = 1'b1;
              wrn_d   = ~pwrite_i;
              add_d   = paddr_i[3:2];
              data_d  = pwdata_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d  = DONE;
            pready_d = 1'b1;
            if (paddr_i[4:2] == 3'b100) begin
              if (pwrite_i) begin
                sticky_clr_s = pwdata_i[1];
              end else begin
                prdata_d = {30'h0000_0000, sticky_q, lock_sync_q};
              end
            end else begin
              pslverr_d = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_inc_s;
        if (fll_ack_i) begin
          state_d = ACK_LOW;
          rdata_d = wrn_q ? fll_r_data_i : 32'h0000_0000;
        end else if (cnt_inc_s == TO_CNT) begin
          state_d      = DONE;
          pready_d     = 1'b1;
          pslverr_d    = 1'b1;
          sticky_set_s = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      ACK_LOW: begin
        cnt_d = cnt_inc_s;
        if (fll_ack_i == 1'b0) begin
          state_d  = DONE;
          pready_d = 1'b1;
          prdata_d = rdata_q;
        end else if (cnt_inc_s == TO_CNT) begin
          state_d      = DONE;
          pready_d     = 1'b1;
          pslverr_d    = 1'b1;
          sticky_set_s = 1'b1;
        end else begin
          state_d = ACK_LOW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sticky_d = (sticky_q & ~sticky_clr_s) | sticky_set_s;
  end

  // State, output registers and lock synchroniser
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      req_q       <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= 32'h0000_0000;
      wrn_q       <= 1'b1;
      add_q       <= 2'd0;
      data_q      <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      sticky_q    <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      wrn_q       <= wrn_d;
      add_q       <= add_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      sticky_q    <= sticky_d;
      lock_meta_q <= fll_lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign prdata_o   = prdata_q;
  assign pready_o   = pready_q;
  assign pslverr_o  = pslverr_q;
  assign fll_req_o  = req_q;
  assign fll_wrn_o  = wrn_q;
  assign fll_add_o  = add_q;
  assign fll_data_o = data_q;

endmodule

// File: tb/tb_fll_cfg_bridge.sv
// Directed bench for fll_cfg_bridge: one default-timeout instance and one with
// an 8-cycle timeout, sharing an APB master.
module tb_fll_cfg_bridge;

  logic        clk, rst;
  logic        psel, penable, pwrite, sel_to;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        lock;

  logic        stub_m, ack_m_drv, stub_t, ack_t_drv;
  logic [31:0] rdata_m_drv;

  logic [31:0] prdata_m, prdata_t, fll_data_m, fll_data_t;
  logic        pready_m, pready_t, pslverr_m, pslverr_t;
  logic        fll_req_m, fll_req_t, fll_wrn_m, fll_wrn_t;
  logic [1:0]  fll_add_m, fll_add_t;
  logic        ack_m, ack_t, psel_m, psel_t;

  int total = 0;
  int bad   = 0;
  int req_cnt_m = 0;
  int req_cnt_t = 0;
  logic        last_wrn_m, last_wrn_t;
  logic [1:0]  last_add_m, last_add_t;
  logic [31:0] last_data_m, last_data_t;

  assign ack_m  = stub_m ? fll_req_m : ack_m_drv;
  assign ack_t  = stub_t ? fll_req_t : ack_t_drv;
  assign psel_m = psel & ~sel_to;
  assign psel_t = psel & sel_to;

  fll_cfg_bridge dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel_m), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata_m), .pready_o(pready_m), .pslverr_o(pslverr_m),
    .fll_req_o(fll_req_m), .fll_wrn_o(fll_wrn_m), .fll_add_o(fll_add_m),
    .fll_data_o(fll_data_m), .fll_ack_i(ack_m), .fll_r_data_i(rdata_m_drv),
    .fll_lock_i(lock)
  );

  fll_cfg_bridge #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk_i(clk), .rst_i(rst), .psel_i(psel_t), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata_t), .pready_o(pready_t), .pslverr_o(pslverr_t),
    .fll_req_o(fll_req_t), .fll_wrn_o(fll_wrn_t), .fll_add_o(fll_add_t),
    .fll_data_o(fll_data_t), .fll_ack_i(ack_t), .fll_r_data_i(32'hFFFF_FFFF),
    .fll_lock_i(lock)
  );

  always #5 clk = ~clk;

  // Count request-high cycles and capture the FLL command while requesting
  always @(negedge clk) begin
    if (fll_req_m) begin
      req_cnt_m   <= req_cnt_m + 1;
      last_wrn_m  <= fll_wrn_m;
      last_add_m  <= fll_add_m;
      last_data_m <= fll_data_m;
    end
    if (fll_req_t) begin
      req_cnt_t   <= req_cnt_t + 1;
      last_wrn_t  <= fll_wrn_t;
      last_add_t  <= fll_add_t;
      last_data_t <= fll_data_t;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    waits = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if ((sel_to ? pready_t : pready_m) === 1'b1) begin
        waits = n;
        break;
      end
    end
    rd  = sel_to ? prdata_t : prdata_m;
    err = sel_to ? pslverr_t : pslverr_m;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          w, n0;

  initial begin
    clk = 1'b0; rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'h0; lock = 1'b0; sel_to = 1'b0;
    stub_m = 1'b0; ack_m_drv = 1'b0; stub_t = 1'b0; ack_t_drv = 1'b0;
    rdata_m_drv = 32'h0;

    #12;
    chk("rst_prdata", prdata_m, 32'h0);
    chk("rst_pready", {31'h0, pready_m}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr_m}, 32'h0);
    chk("rst_req", {31'h0, fll_req_m}, 32'h0);
    chk("rst_wrn", {31'h0, fll_wrn_m}, 32'h1);
    chk("rst_add", {30'h0, fll_add_m}, 32'h0);
    chk("rst_data", fll_data_m, 32'h0);
    @(negedge clk); rst = 1'b0;

    // stub write to register 2
    stub_m = 1'b1;
    n0 = req_cnt_m;
    apb(1'b1, 12'h008, 32'hDEAD_BEEF, rd, err, w);
    chk("stub_wait", w, 32'd3);
    chk("stub_err", {31'h0, err}, 32'h0);
    chk("stub_reqcyc", req_cnt_m - n0, 32'd1);
    chk("stub_wrn", {31'h0, last_wrn_m}, 32'h0);
    chk("stub_add", {30'h0, last_add_m}, 32'h2);
    chk("stub_data", last_data_m, 32'hDEAD_BEEF);

    // delayed read of register 1: ack rises 5 after req, falls 2 after req drops
    stub_m = 1'b0;
    fork
      apb(1'b0, 12'h004, 32'h0, rd, err, w);
      begin : ack_drv
        int i;
        i = 0;
        do begin @(negedge clk); i++; end while (!fll_req_m && i < 50);
        repeat (5) @(negedge clk);
        ack_m_drv = 1'b1; rdata_m_drv = 32'h1234_5678;
        i = 0;
        do begin @(negedge clk); i++; end while (fll_req_m && i < 50);
        repeat (2) @(negedge clk);
        ack_m_drv = 1'b0; rdata_m_drv = 32'h0;
      end
    join
    chk("dly_wait", w, 32'd10);
    chk("dly_rdata", rd, 32'h1234_5678);
    chk("dly_err", {31'h0, err}, 32'h0);
    chk("dly_add", {30'h0, last_add_m}, 32'h1);
    chk("dly_wrn", {31'h0, last_wrn_m}, 32'h1);

    // lock visibility and unmapped access
    lock = 1'b1;
    repeat (4) @(negedge clk);
    apb(1'b0, 12'h010, 32'h0, rd, err, w);
    chk("lock_status", rd, 32'h1);
    chk("lock_wait", w, 32'd1);
    chk("lock_err", {31'h0, err}, 32'h0);
    apb(1'b0, 12'h018, 32'h0, rd, err, w);
    chk("unmap_rdata", rd, 32'h0);
    chk("unmap_err", {31'h0, err}, 32'h1);
    chk("unmap_wait", w, 32'd1);
    lock = 1'b0;
    repeat (4) @(negedge clk);

    // timeout on the 8-cycle instance with ack stuck low
    sel_to = 1'b1;
    n0 = req_cnt_t;
    apb(1'b1, 12'h000, 32'hA5A5_0001, rd, err, w);
    chk("to_wait", w, 32'd9);
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_reqcyc", req_cnt_t - n0, 32'd8);
    apb(1'b0, 12'h010, 32'h0, rd, err, w);
    chk("to_status", rd, 32'h2);
    apb(1'b1, 12'h010, 32'h2, rd, err, w);
    chk("to_clr_err", {31'h0, err}, 32'h0);
    apb(1'b0, 12'h010, 32'h0, rd, err, w);
    chk("to_status_clr", rd, 32'h0);

    // stale acknowledge held high, then released into stub mode
    ack_t_drv = 1'b1;
    n0 = req_cnt_t;
    fork
      apb(1'b1, 12'h004, 32'h0BAD_CAFE, rd, err, w);
      begin
        @(negedge clk); @(negedge clk);
        repeat (4) @(negedge clk);
        chk("stale_noreq", req_cnt_t - n0, 32'd0);
        ack_t_drv = 1'b0; stub_t = 1'b1;
      end
    join
    chk("stale_wait", w, 32'd7);
    chk("stale_err", {31'h0, err}, 32'h0);
    chk("stale_reqcyc", req_cnt_t - n0, 32'd1);
    chk("stale_data", last_data_t, 32'h0BAD_CAFE);
    sel_to = 1'b0;

    // reset while in REQ
    stub_m = 1'b0; ack_m_drv = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h1111_2222;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_before", {31'h0, fll_req_m}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_req", {31'h0, fll_req_m}, 32'h0);
    chk("rstmid_wrn", {31'h0, fll_wrn_m}, 32'h1);
    repeat (3) @(negedge clk);
    chk("rstmid_pready", {31'h0, pready_m}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst = 1'b0;

    stub_m = 1'b1;
    n0 = req_cnt_m;
    apb(1'b1, 12'h008, 32'hDEAD_BEEF, rd, err, w);
    chk("post_rst_wait", w, 32'd3);
    chk("post_rst_err", {31'h0, err}, 32'h0);
    chk("post_rst_reqcyc", req_cnt_m - n0, 32'd1);
    chk("post_rst_data", last_data_m, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
